wall_column_feeder: RTL and testbench

Streams wall columns from the level-map ROM into the game datapath, replacing the hard-coded wall patterns the physics step shifts in. It reads COL_HEIGHT/WORD_W ROM words per column, assembles a COL_HEIGHT-bit column, and presents it with a valid/request handshake. The game FSM pulses `start` from MENU and `req` from PHYSICS. The block sits between the map ROM and `datapath`.

---
 rtl/wall_column_feeder.sv | 187 ++++++++++++++++++
 tb/tb_wall_column_feeder.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wall_column_feeder.sv
// wall_column_feeder
//   Streams wall columns from the level-map ROM into the game datapath.
//   Each column is COL_HEIGHT bits wide, read as WPC = COL_HEIGHT/WORD_W
//   consecutive ROM words. Word k of column c lives at c*WPC+k and lands
//   in col_data[k*WORD_W +: WORD_W]. Bit 0 of col_data is the top row.
//
// Ports
//   clk        system clock
//   resetn     asynchronous active-low reset
//   start      pulse: rewind to column 0 and prefetch it (wins over req)
//   req        pulse: datapath consumes the presented column this cycle
//   col_valid  col_data holds a complete column
//   col_data   assembled column
//   busy       fetch in progress (FETCH or DRAIN)
//   map_end    sticky: last column consumed (non-looping build only)
//   underrun   sticky: req arrived while a fetch was still in progress
//   rom_rd     ROM read strobe
//   rom_addr   ROM word address (holds its value when rom_rd=0)
//   rom_data   ROM output, valid the cycle after rom_rd/rom_addr
//
// Build option
//   WALL_MAP_LOOP_EN  defined: wrap to column 0 after the last column
//                     (endless map). Undefined: stop in DONE, raise map_end.
//
// state | meaning
// IDLE  | after reset, waiting for start
// FETCH | issuing the WPC reads of a column
// DRAIN | capturing the final word of the column
// READY | column presented, col_valid=1
// DONE  | map exhausted, no further reads
module wall_column_feeder #(
  parameter int COL_HEIGHT = 100,
  parameter int WORD_W     = 20,
  parameter int MAP_COLS   = 64,
  parameter int ADDR_W     = 9
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic                  req,
  output logic                  col_valid,
  output logic [COL_HEIGHT-1:0] col_data,
  output logic                  busy,
  output logic                  map_end,
  output logic                  underrun,
  output logic                  rom_rd,
  output logic [ADDR_W-1:0]     rom_addr,
  input  logic [WORD_W-1:0]     rom_data
);

  localparam int WPC = COL_HEIGHT / WORD_W;
  localparam int KW  = (WPC > 1) ? $clog2(WPC) : 1;
  localparam int CW  = (MAP_COLS > 1) ? $clog2(MAP_COLS) : 1;
  localparam logic [KW-1:0]     K_LAST    = KW'(WPC - 1);
  localparam logic [CW-1:0]     C_LAST    = CW'(MAP_COLS - 1);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(WPC);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DRAIN, S_READY, S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic                    rom_rd_q, rom_rd_d;
  logic [ADDR_W-1:0]       rom_addr_q, rom_addr_d;
  logic [ADDR_W-1:0]       base_q, base_d;
  logic [CW-1:0]           col_idx_q, col_idx_d;
  logic [KW-1:0]           word_q, word_d;
  logic [COL_HEIGHT-1:0]   col_q, col_d;
  logic                    map_end_q, map_end_d;
  logic                    underrun_q, underrun_d;
  logic                    cap_en;
  logic [KW-1:0]           cap_slot;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      rom_rd_q   <= 1'b0;
      rom_addr_q <= '0;
      base_q     <= '0;
      col_idx_q  <= '0;
      word_q     <= '0;
      col_q      <= '0;
      map_end_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rom_rd_q   <= rom_rd_d;
      rom_addr_q <= rom_addr_d;
      base_q     <= base_d;
      col_idx_q  <= col_idx_d;
      word_q     <= word_d;
      col_q      <= col_d;
      map_end_q  <= map_end_d;
      underrun_q <= underrun_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rom_rd_d   = 1'b0;
    rom_addr_d = rom_addr_q;
    base_d     = base_q;
    col_idx_d  = col_idx_q;
    word_d     = word_q;
    map_end_d  = map_end_q;
    underrun_d = underrun_q;
    cap_en     = 1'b0;
    cap_slot   = '0;

    case (state_q)
      S_FETCH: begin
        // rom_data now carries the word addressed in the previous cycle
        if (word_q != '0) begin
          cap_en   = 1'b1;
          cap_slot = word_q - 1'b1;
        end
        if (word_q == K_LAST) begin
          state_d = S_DRAIN;
        end else begin
          rom_rd_d   = 1'b1;
          rom_addr_d = rom_addr_q + ADDR_W'(1);
          word_d     = word_q + 1'b1;
        end
        if (req) underrun_d = 1'b1;
      end
      S_DRAIN: begin
        cap_en   = 1'b1;
        cap_slot = K_LAST;
        state_d  = S_READY;
        if (req) underrun_d = 1'b1;
      end
      S_READY: begin
        if (req) begin
          if (col_idx_q == C_LAST) begin
`ifdef WALL_MAP_LOOP_EN
            col_idx_d  = '0;
            base_d     = '0;
            state_d    = S_FETCH;
            rom_rd_d   = 1'b1;
            rom_addr_d = '0;
            word_d     = '0;
`else
            state_d   = S_DONE;
            map_end_d = 1'b1;
`endif
          end else begin
            col_idx_d  = col_idx_q + 1'b1;
            base_d     = base_q + ADDR_STEP;
            state_d    = S_FETCH;
            rom_rd_d   = 1'b1;
            rom_addr_d = base_q + ADDR_STEP;
            word_d     = '0;
          end
        end
      end
      default: ;
    endcase

    // start overrides everything, including a simultaneous req
    if (start) begin
      state_d    = S_FETCH;
      rom_rd_d   = 1'b1;
      rom_addr_d = '0;
      base_d     = '0;
      col_idx_d  = '0;
      word_d     = '0;
      map_end_d  = 1'b0;
      underrun_d = 1'b0;
    end
  end

  always_comb begin
    col_d = col_q;
    for (int i = 0; i < WPC; i++) begin
      if (cap_en && cap_slot == KW'(i)) col_d[i*WORD_W +: WORD_W] = rom_data;
    end
  end

  assign col_valid = (state_q == S_READY);
  assign busy      = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign col_data  = col_q;
  assign map_end   = map_end_q;
  assign underrun  = underrun_q;
  assign rom_rd    = rom_rd_q;
  assign rom_addr  = rom_addr_q;

endmodule

// File: tb/tb_wall_column_feeder.sv
module tb_wall_column_feeder;

  localparam int COL_HEIGHT = 100;
  localparam int WORD_W     = 20;
  localparam int MAP_COLS   = 64;
  localparam int ADDR_W     = 9;
  localparam int WPC        = 5;

  logic                  clk = 1'b0;
  logic                  resetn = 1'b0;
  logic                  start = 1'b0;
  logic                  req = 1'b0;
  logic                  col_valid;
  logic [COL_HEIGHT-1:0] col_data;
  logic                  busy;
  logic                  map_end;
  logic                  underrun;
  logic                  rom_rd;
  logic [ADDR_W-1:0]     rom_addr;
  logic [WORD_W-1:0]     rom_data = '0;

  int n_cmp = 0;
  int n_bad = 0;

  wall_column_feeder #(
    .COL_HEIGHT(COL_HEIGHT), .WORD_W(WORD_W), .MAP_COLS(MAP_COLS), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .req(req),
    .col_valid(col_valid), .col_data(col_data), .busy(busy),
    .map_end(map_end), .underrun(underrun), .rom_rd(rom_rd),
    .rom_addr(rom_addr), .rom_data(rom_data)
  );

  always #5 clk = ~clk;

  // ROM model: word content equals its address, one cycle read latency
  always @(posedge clk) if (rom_rd) rom_data <= {{(WORD_W-ADDR_W){1'b0}}, rom_addr};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [COL_HEIGHT-1:0] col_of(input int base);
    logic [COL_HEIGHT-1:0] v;
    v = '0;
    for (int k = 0; k < WPC; k++) v[k*WORD_W +: WORD_W] = WORD_W'(base + k);
    return v;
  endfunction

  task automatic wait_valid(input string tag);
    int i;
    i = 0;
    while (!col_valid && i < 20) begin
      tick();
      i++;
    end
    n_cmp++;
    if (col_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_timeout col_valid=%b after %0d cycles, want 1", tag, col_valid, i);
    end
  endtask

  task automatic test_reset;
    #2;
    n_cmp++;
    if ({col_valid, busy, map_end, underrun, rom_rd} !== 5'b0 || rom_addr !== '0 || col_data !== '0) begin
      n_bad++;
      $display("FAIL reset_vals valid=%b busy=%b end=%b und=%b rd=%b addr=%0d data=%h want all 0",
               col_valid, busy, map_end, underrun, rom_rd, rom_addr, col_data);
    end
    tick();
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_start_fetch;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= WPC; c++) begin
      n_cmp++;
      if (rom_rd !== 1'b1 || rom_addr !== ADDR_W'(c-1) || busy !== 1'b1 || col_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL fetch0_read cyc=%0d rd=%b addr=%0d busy=%b valid=%b want rd=1 addr=%0d busy=1 valid=0",
                 c, rom_rd, rom_addr, busy, col_valid, c-1);
      end
      tick();
    end
    n_cmp++;
    if (rom_rd !== 1'b0 || busy !== 1'b1 || col_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL fetch0_drain rd=%b busy=%b valid=%b want 0 1 0", rom_rd, busy, col_valid);
    end
    tick();
    n_cmp++;
    if (col_valid !== 1'b1 || busy !== 1'b0 || col_data !== col_of(0)) begin
      n_bad++;
      $display("FAIL fetch0_col cyc=7 valid=%b busy=%b data=%h want 1 0 %h", col_valid, busy, col_data, col_of(0));
    end
    for (int c = 8; c <= 10; c++) begin
      tick();
      n_cmp++;
      if (col_valid !== 1'b1 || rom_rd !== 1'b0 || rom_addr !== ADDR_W'(4)) begin
        n_bad++;
        $display("FAIL ready_hold cyc=%0d valid=%b rd=%b addr=%0d want 1 0 4", c, col_valid, rom_rd, rom_addr);
      end
    end
    // cycle 10: consume column 0
    req = 1'b1;
    tick();
    req = 1'b0;
    for (int c = 11; c <= 15; c++) begin
      n_cmp++;
      if (col_valid !== 1'b0 || rom_rd !== 1'b1 || rom_addr !== ADDR_W'(c-6)) begin
        n_bad++;
        $display("FAIL fetch1_read cyc=%0d valid=%b rd=%b addr=%0d want 0 1 %0d", c, col_valid, rom_rd, rom_addr, c-6);
      end
      tick();
    end
    n_cmp++;
    if (col_valid !== 1'b0 || rom_rd !== 1'b0) begin
      n_bad++;
      $display("FAIL fetch1_drain valid=%b rd=%b want 0 0", col_valid, rom_rd);
    end
    tick();
    n_cmp++;
    if (col_valid !== 1'b1 || col_data !== col_of(5) || underrun !== 1'b0) begin
      n_bad++;
      $display("FAIL fetch1_col cyc=17 valid=%b data=%h und=%b want 1 %h 0", col_valid, col_data, underrun, col_of(5));
    end
  endtask

  task automatic test_underrun;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    req = 1'b1;      // cycle 3, mid-fetch
    tick();
    req = 1'b0;
    n_cmp++;
    if (underrun !== 1'b1 || rom_rd !== 1'b1 || rom_addr !== ADDR_W'(3)) begin
      n_bad++;
      $display("FAIL underrun_set und=%b rd=%b addr=%0d want 1 1 3", underrun, rom_rd, rom_addr);
    end
    tick();
    tick();
    tick();
    n_cmp++;
    if (col_valid !== 1'b1 || col_data !== col_of(0) || underrun !== 1'b1) begin
      n_bad++;
      $display("FAIL underrun_col cyc=7 valid=%b data=%h und=%b want 1 %h 1", col_valid, col_data, underrun, col_of(0));
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++;
    if (underrun !== 1'b0 || rom_rd !== 1'b1 || rom_addr !== '0) begin
      n_bad++;
      $display("FAIL underrun_clear und=%b rd=%b addr=%0d want 0 1 0", underrun, rom_rd, rom_addr);
    end
    wait_valid("underrun_refetch");
  endtask

  task automatic test_priority;
    req = 1'b1;
    tick();
    req = 1'b0;
    wait_valid("prio_col1");
    n_cmp++;
    if (col_data !== col_of(5)) begin
      n_bad++;
      $display("FAIL prio_col1_data data=%h want %h", col_data, col_of(5));
    end
    start = 1'b1;
    req = 1'b1;
    tick();
    start = 1'b0;
    req = 1'b0;
    n_cmp++;
    if (rom_rd !== 1'b1 || rom_addr !== '0 || col_valid !== 1'b0 || underrun !== 1'b0) begin
      n_bad++;
      $display("FAIL prio_start_wins rd=%b addr=%0d valid=%b und=%b want 1 0 0 0", rom_rd, rom_addr, col_valid, underrun);
    end
    wait_valid("prio_rewind");
    n_cmp++;
    if (col_data !== col_of(0)) begin
      n_bad++;
      $display("FAIL prio_rewind_data data=%h want %h", col_data, col_of(0));
    end
    req = 1'b1;
    tick();
    req = 1'b0;
    n_cmp++;
    if (rom_addr !== ADDR_W'(5) || rom_rd !== 1'b1) begin
      n_bad++;
      $display("FAIL prio_next_col addr=%0d rd=%b want 5 1", rom_addr, rom_rd);
    end
  endtask

  task automatic test_reset_mid;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();          // cycle 3 of the fetch
    #2;
    resetn = 1'b0;
    #1;
    n_cmp++;
    if ({col_valid, busy, map_end, underrun, rom_rd} !== 5'b0 || rom_addr !== '0 || col_data !== '0) begin
      n_bad++;
      $display("FAIL reset_async valid=%b busy=%b end=%b und=%b rd=%b addr=%0d data=%h want all 0",
               col_valid, busy, map_end, underrun, rom_rd, rom_addr, col_data);
    end
    tick();
    resetn = 1'b1;
    tick();
    req = 1'b1;
    tick();
    req = 1'b0;
    tick();
    n_cmp++;
    if (busy !== 1'b0 || rom_rd !== 1'b0 || col_valid !== 1'b0 || underrun !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle busy=%b rd=%b valid=%b und=%b want 0 0 0 0", busy, rom_rd, col_valid, underrun);
    end
  endtask

  task automatic test_exhaust;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int col = 0; col < MAP_COLS; col++) begin
      wait_valid("exhaust");
      n_cmp++;
      if (col_data !== col_of(col*WPC)) begin
        n_bad++;
        $display("FAIL exhaust_data col=%0d data=%h want %h", col, col_data, col_of(col*WPC));
      end
      req = 1'b1;
      tick();
      req = 1'b0;
      if (col < MAP_COLS-1) begin
        n_cmp++;
        if (col_valid !== 1'b0 || rom_rd !== 1'b1 || rom_addr !== ADDR_W'((col+1)*WPC) || map_end !== 1'b0) begin
          n_bad++;
          $display("FAIL exhaust_next col=%0d valid=%b rd=%b addr=%0d end=%b want 0 1 %0d 0",
                   col, col_valid, rom_rd, rom_addr, map_end, (col+1)*WPC);
        end
      end
    end
`ifdef WALL_MAP_LOOP_EN
    n_cmp++;
    if (map_end !== 1'b0 || rom_rd !== 1'b1 || rom_addr !== '0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL loop_wrap end=%b rd=%b addr=%0d busy=%b want 0 1 0 1", map_end, rom_rd, rom_addr, busy);
    end
    wait_valid("loop_refetch");
    n_cmp++;
    if (col_data !== col_of(0) || map_end !== 1'b0) begin
      n_bad++;
      $display("FAIL loop_data data=%h end=%b want %h 0", col_data, map_end, col_of(0));
    end
`else
    n_cmp++;
    if (map_end !== 1'b1 || col_valid !== 1'b0 || busy !== 1'b0 || rom_rd !== 1'b0) begin
      n_bad++;
      $display("FAIL done_enter end=%b valid=%b busy=%b rd=%b want 1 0 0 0", map_end, col_valid, busy, rom_rd);
    end
    req = 1'b1;
    tick();
    req = 1'b0;
    for (int c = 0; c < 4; c++) begin
      n_cmp++;
      if (rom_rd !== 1'b0 || map_end !== 1'b1 || underrun !== 1'b0 || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL done_hold c=%0d rd=%b end=%b und=%b busy=%b want 0 1 0 0", c, rom_rd, map_end, underrun, busy);
      end
      tick();
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++;
    if (map_end !== 1'b0 || rom_rd !== 1'b1 || rom_addr !== '0) begin
      n_bad++;
      $display("FAIL done_restart end=%b rd=%b addr=%0d want 0 1 0", map_end, rom_rd, rom_addr);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_start_fetch();
    test_underrun();
    test_priority();
    test_reset_mid();
    test_exhaust();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
